// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expander: one schedule word per clock,
// full schedule held on-chip, registered round-key read port.
module aes_key_schedule_seq #(
    parameter int MAX_NK = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           key_len,
    input  logic [0:32*MAX_NK-1] key,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           nr_out,
    input  logic [3:0]           rk_idx,
    output logic [0:127]         rk_out,
    output logic                 rk_valid
);
    localparam int MAX_NR = MAX_NK + 6;
    localparam int NWORDS = 4 * (MAX_NR + 1);
    localparam int IW     = $clog2(NWORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
        S_DONE
    } state_t;

    state_t        state;
    logic [31:0]   w [NWORDS];
    logic [3:0]    nk_q;
    logic [3:0]    nr_q;
    logic [3:0]    j_q;
    logic [IW-1:0] i_q;
    logic [IW-1:0] last_q;
    logic [7:0]    rcon;

    logic [3:0]    nk_sel;
    logic [3:0]    nr_sel;
    logic          len_ok;
    logic [31:0]   prev;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   temp;
    logic [IW-1:0] rd_base;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n])
                p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box from first principles: x^254 inverse, then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int n = 1; n < 8; n++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    always_comb begin
        nk_sel = 4'd4;
        nr_sel = 4'd10;
        len_ok = 1'b0;
        unique case (key_len)
            2'd0: begin
                nk_sel = 4'd4;
                nr_sel = 4'd10;
                len_ok = 1'b1;
            end
            2'd1: begin
                nk_sel = 4'd6;
                nr_sel = 4'd12;
                len_ok = (MAX_NK >= 6);
            end
            2'd2: begin
                nk_sel = 4'd8;
                nr_sel = 4'd14;
                len_ok = (MAX_NK >= 8);
            end
            default: len_ok = 1'b0;
        endcase
    end

    // Shared SubWord unit: RotWord only on the Nk-aligned word
    always_comb begin
        prev   = w[i_q - IW'(1)];
        sub_in = (j_q == 4'd0) ? {prev[23:0], prev[31:24]} : prev;
        for (int k = 0; k < 4; k++)
            sub_out[8*k +: 8] = sbox(sub_in[8*k +: 8]);
        temp = prev;
        if (j_q == 4'd0)
            temp = sub_out ^ {rcon, 24'h0};
        else if (nk_q == 4'd8 && j_q == 4'd4)
            temp = sub_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rk_valid <= 1'b0;
            nr_out   <= '0;
            nk_q     <= '0;
            nr_q     <= '0;
            j_q      <= '0;
            i_q      <= '0;
            last_q   <= '0;
            rcon     <= '0;
            for (int n = 0; n < NWORDS; n++)
                w[n] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && len_ok) begin
                        nk_q     <= nk_sel;
                        nr_q     <= nr_sel;
                        last_q   <= IW'({nr_sel, 2'b11});
                        rk_valid <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int n = 0; n < MAX_NK; n++)
                        if (4'(n) < nk_q)
                            w[n] <= key[32*n +: 32];
                    i_q    <= IW'(nk_q);
                    j_q    <= '0;
                    rcon   <= 8'h01;
                    nr_out <= nr_q;
                    state  <= S_EXPAND;
                end
                S_EXPAND: begin
                    w[i_q] <= w[i_q - IW'(nk_q)] ^ temp;
                    i_q    <= i_q + IW'(1);
                    j_q    <= (j_q == nk_q - 4'd1) ? 4'd0 : j_q + 4'd1;
                    if (j_q == 4'd0)
                        rcon <= xtime(rcon);
                    if (i_q == last_q) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rk_valid <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rd_base = IW'({rk_idx, 2'b00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rk_out <= '0;
        else if (rk_idx > nr_q)
            rk_out <= '0;
        else
            rk_out <= {w[rd_base],
                       w[rd_base + IW'(1)],
                       w[rd_base + IW'(2)],
                       w[rd_base + IW'(3)]};
    end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed + randomized bench for aes_key_schedule_seq against a
// table-driven FIPS-197 key-expansion model.
module tb_aes_key_schedule_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [0:255] key = '0;
    logic         busy;
    logic         done;
    logic [3:0]   nr_out;
    logic [3:0]   rk_idx = 4'd0;
    logic [0:127] rk_out;
    logic         rk_valid;

    int tests = 0;
    int fails = 0;

    aes_key_schedule_seq #(.MAX_NK(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_len  (key_len),
        .key      (key),
        .busy     (busy),
        .done     (done),
        .nr_out   (nr_out),
        .rk_idx   (rk_idx),
        .rk_out   (rk_out),
        .rk_valid (rk_valid)
    );

    always #5 clk = ~clk;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0]  rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [31:0] mw [0:59];

    localparam logic [255:0] K128 =
        {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 =
        {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    task automatic model(input logic [255:0] k, input int nk);
        int nr;
        logic [31:0] t;
        nr = nk + 6;
        for (int i = 0; i < 60; i++)
            mw[i] = '0;
        for (int i = 0; i < nk; i++)
            mw[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = mw[i-1];
            if (i % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
            else if (nk > 6 && i % nk == 4)
                t = subw(t);
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] rk_exp(input int idx, input int nr);
        if (idx > nr)
            return '0;
        return {mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input int idx,
                            input logic [127:0] exp);
        @(negedge clk);
        rk_idx = 4'(idx);
        @(posedge clk);
        #1;
        check(tag, rk_out, exp);
    endtask

    // Start one expansion and watch 70 edges; optional busy-start/reset
    task automatic run(input logic [255:0] k, input logic [1:0] len,
                       input bit inj, input int rst_at,
                       output int d_edge, output int d_cnt);
        int nk;
        int nw;
        nk = 4 + 2*int'(len);
        nw = 4*(nk + 7) - nk;
        d_edge = -1;
        d_cnt = 0;
        @(negedge clk);
        key = k;
        key_len = len;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk);
            #1;
            if (inj && n == 10) begin
                start = 1'b1;
                key = ~k;
                key_len = 2'd2;
            end
            if (inj && n == 11) begin
                start = 1'b0;
                key = k;
                key_len = len;
            end
            if (rst_at > 0 && n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 128'(busy), 128'(0));
                check("rst_done", 128'(done), 128'(0));
                check("rst_valid", 128'(rk_valid), 128'(0));
                check("rst_nr", 128'(nr_out), 128'(0));
                check("rst_rk", 128'(rk_out), 128'(0));
            end
            if (rst_at == 0 && n == nw)
                check("busy_hi", 128'(busy), 128'(1));
            if (rst_at == 0 && n == nw + 1)
                check("busy_lo", 128'(busy), 128'(0));
            if (done) begin
                d_cnt++;
                if (d_edge < 0)
                    d_edge = n;
            end
        end
        if (rst_at > 0) begin
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    initial begin
        int de;
        int dc;
        int len;
        int nr;
        logic [255:0] rk;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_valid", 128'(rk_valid), 128'(0));
        check("reset_nr", 128'(nr_out), 128'(0));
        check("reset_rk", 128'(rk_out), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run(K128, 2'd0, 1'b0, 0, de, dc);
        model(K128, 4);
        check("a1_done_edge", 128'(de), 128'(41));
        check("a1_done_cnt", 128'(dc), 128'(1));
        check("a1_nr", 128'(nr_out), 128'(10));
        check("a1_valid", 128'(rk_valid), 128'(1));
        read_chk("a1_rk0", 0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_chk("a1_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
        read_chk("a1_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int i = 0; i < 16; i++)
            read_chk("a1_sweep", i, rk_exp(i, 10));

        @(negedge clk);
        key_len = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key_len = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("ill_busy", 128'(busy), 128'(0));
        check("ill_valid", 128'(rk_valid), 128'(1));
        check("ill_nr", 128'(nr_out), 128'(10));
        read_chk("ill_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run(K128, 2'd0, 1'b1, 0, de, dc);
        check("bsy_done_edge", 128'(de), 128'(41));
        check("bsy_done_cnt", 128'(dc), 128'(1));
        read_chk("bsy_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run(K192, 2'd1, 1'b0, 0, de, dc);
        check("a2_done_edge", 128'(de), 128'(47));
        check("a2_done_cnt", 128'(dc), 128'(1));
        check("a2_nr", 128'(nr_out), 128'(12));
        read_chk("a2_rk12", 12, 128'he98ba06f448c773c8ecc720401002202);

        run(K256, 2'd2, 1'b0, 0, de, dc);
        check("a3_done_edge", 128'(de), 128'(53));
        check("a3_done_cnt", 128'(dc), 128'(1));
        check("a3_nr", 128'(nr_out), 128'(14));
        read_chk("a3_rk14", 14, 128'hfe4890d1e6188d0b046df344706c631e);

        run(K256, 2'd2, 1'b0, 22, de, dc);
        check("rst_no_done", 128'(dc), 128'(0));
        check("rst_valid_after", 128'(rk_valid), 128'(0));

        run(K128, 2'd0, 1'b0, 0, de, dc);
        check("post_done_edge", 128'(de), 128'(41));
        read_chk("post_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
        read_chk("post_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(0, 2));
            nr = 10 + 2*len;
            for (int m = 0; m < 8; m++)
                rk[255 - 32*m -: 32] = $urandom();
            run(rk, 2'(len), 1'b0, 0, de, dc);
            model(rk, 4 + 2*len);
            check("rnd_done_edge", 128'(de), 128'(4*(nr+1) - (4+2*len) + 1));
            check("rnd_nr", 128'(nr_out), 128'(nr));
            for (int i = 0; i < 16; i++)
                read_chk("rnd_rk", i, rk_exp(i, nr));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
